// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the elastic ID/EX pipeline register.
package id_ex_pkg;

  localparam int unsigned PC_WIDTH_DEF   = 64;
  localparam int unsigned REG_WIDTH_DEF  = 64;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned EX_CTRL_W_DEF  = 5;
  localparam int unsigned M_CTRL_W_DEF   = 5;
  localparam int unsigned WB_CTRL_W_DEF  = 5;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned FUNCT3_W       = 3;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Total payload width for a given set of field widths.
  function automatic int unsigned payload_w(
    input int unsigned pc_w,
    input int unsigned reg_w,
    input int unsigned addr_w,
    input int unsigned ex_w,
    input int unsigned m_w,
    input int unsigned wb_w
  );
    return pc_w + 3 * reg_w + FUNCT3_W + 3 * addr_w + ex_w + m_w + wb_w;
  endfunction

  localparam int unsigned ID_EX_PAYLOAD_W = payload_w(PC_WIDTH_DEF, REG_WIDTH_DEF,
    REG_ADDR_W_DEF, EX_CTRL_W_DEF, M_CTRL_W_DEF, WB_CTRL_W_DEF);

  // Payload layout at the default widths.
  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]   pc;
    logic [REG_WIDTH_DEF-1:0]  rs1_data;
    logic [REG_WIDTH_DEF-1:0]  rs2_data;
    logic [REG_WIDTH_DEF-1:0]  imm;
    logic [FUNCT3_W-1:0]       funct3;
    logic [REG_ADDR_W_DEF-1:0] rs1_addr;
    logic [REG_ADDR_W_DEF-1:0] rs2_addr;
    logic [REG_ADDR_W_DEF-1:0] rd_addr;
    logic [EX_CTRL_W_DEF-1:0]  ex_ctrl;
    logic [M_CTRL_W_DEF-1:0]   m_ctrl;
    logic [WB_CTRL_W_DEF-1:0]  wb_ctrl;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: valid/ready on both sides, synchronous flush.
// in_ready is a pure decode of the state register, so it has no combinational
// path from out_ready.
module pipe_skid_buf
  import id_ex_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             load_main_in, load_main_skid, load_skid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and entry load strobes; flush overrides every transfer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            load_main_in = 1'b1;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            load_main_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main (head) and skid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_data;
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// Elastic ID/EX pipeline register: packs the decode bundle into a skid buffer,
// masks the control bundles on bubbles and counts downstream stall cycles.
module id_ex_skid_reg
  import id_ex_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned REG_WIDTH  = REG_WIDTH_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned EX_CTRL_W  = EX_CTRL_W_DEF,
  parameter int unsigned M_CTRL_W   = M_CTRL_W_DEF,
  parameter int unsigned WB_CTRL_W  = WB_CTRL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [REG_WIDTH-1:0]  in_rs1_data,
  input  logic [REG_WIDTH-1:0]  in_rs2_data,
  input  logic [REG_WIDTH-1:0]  in_imm,
  input  logic [2:0]            in_funct3,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [EX_CTRL_W-1:0]  in_ex_ctrl,
  input  logic [M_CTRL_W-1:0]   in_m_ctrl,
  input  logic [WB_CTRL_W-1:0]  in_wb_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [REG_WIDTH-1:0]  out_rs1_data,
  output logic [REG_WIDTH-1:0]  out_rs2_data,
  output logic [REG_WIDTH-1:0]  out_imm,
  output logic [2:0]            out_funct3,
  output logic [REG_ADDR_W-1:0] out_rs1_addr,
  output logic [REG_ADDR_W-1:0] out_rs2_addr,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [EX_CTRL_W-1:0]  out_ex_ctrl,
  output logic [M_CTRL_W-1:0]   out_m_ctrl,
  output logic [WB_CTRL_W-1:0]  out_wb_ctrl,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned PAYLOAD_W =
    payload_w(PC_WIDTH, REG_WIDTH, REG_ADDR_W, EX_CTRL_W, M_CTRL_W, WB_CTRL_W);

  // Same layout as id_ex_payload_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [REG_WIDTH-1:0]  rs1_data;
    logic [REG_WIDTH-1:0]  rs2_data;
    logic [REG_WIDTH-1:0]  imm;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [EX_CTRL_W-1:0]  ex_ctrl;
    logic [M_CTRL_W-1:0]   m_ctrl;
    logic [WB_CTRL_W-1:0]  wb_ctrl;
  } payload_t;

  payload_t in_pl, out_pl;

  // Pack the decode-stage fields.
  always_comb begin
    in_pl          = '0;
    in_pl.pc       = in_pc;
    in_pl.rs1_data = in_rs1_data;
    in_pl.rs2_data = in_rs2_data;
    in_pl.imm      = in_imm;
    in_pl.funct3   = in_funct3;
    in_pl.rs1_addr = in_rs1_addr;
    in_pl.rs2_addr = in_rs2_addr;
    in_pl.rd_addr  = in_rd_addr;
    in_pl.ex_ctrl  = in_ex_ctrl;
    in_pl.m_ctrl   = in_m_ctrl;
    in_pl.wb_ctrl  = in_wb_ctrl;
  end

  pipe_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  // Unpack; control bundles are zeroed on a bubble so EX/MEM/WB see a NOP.
  always_comb begin
    out_pc       = out_pl.pc;
    out_rs1_data = out_pl.rs1_data;
    out_rs2_data = out_pl.rs2_data;
    out_imm      = out_pl.imm;
    out_funct3   = out_pl.funct3;
    out_rs1_addr = out_pl.rs1_addr;
    out_rs2_addr = out_pl.rs2_addr;
    out_rd_addr  = out_pl.rd_addr;
    out_ex_ctrl  = out_valid ? out_pl.ex_ctrl : '0;
    out_m_ctrl   = out_valid ? out_pl.m_ctrl  : '0;
    out_wb_ctrl  = out_valid ? out_pl.wb_ctrl : '0;
  end

  // Saturating count of cycles where EX holds off a valid instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: a depth-2 FIFO model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_id_ex_skid_reg;
  import id_ex_pkg::*;

  localparam int unsigned CW      = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic clk, rst, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  id_ex_payload_t cur;
  logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic [4:0]  out_ex_ctrl, out_m_ctrl, out_wb_ctrl;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int errors  = 0;
  bit seen_squashed = 0;

  id_ex_payload_t mq[$];
  int unsigned    mcnt = 0;

  id_ex_skid_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(cur.pc), .in_rs1_data(cur.rs1_data), .in_rs2_data(cur.rs2_data),
    .in_imm(cur.imm), .in_funct3(cur.funct3),
    .in_rs1_addr(cur.rs1_addr), .in_rs2_addr(cur.rs2_addr), .in_rd_addr(cur.rd_addr),
    .in_ex_ctrl(cur.ex_ctrl), .in_m_ctrl(cur.m_ctrl), .in_wb_ctrl(cur.wb_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_funct3(out_funct3),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_ex_ctrl(out_ex_ctrl), .out_m_ctrl(out_m_ctrl), .out_wb_ctrl(out_wb_ctrl),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic id_ex_payload_t mk(input logic [63:0] pc, input logic [4:0] rd,
                                        input logic [4:0] ex);
    id_ex_payload_t p;
    p.pc       = pc;
    p.rs1_data = pc * 3 + 64'h1111;
    p.rs2_data = pc ^ 64'hDEAD_BEEF_0000_0000;
    p.imm      = ~pc;
    p.funct3   = pc[4:2];
    p.rs1_addr = pc[6:2];
    p.rs2_addr = pc[7:3] ^ 5'h15;
    p.rd_addr  = rd;
    p.ex_ctrl  = ex;
    p.m_ctrl   = pc[8:4] | 5'h01;
    p.wb_ctrl  = ~ex | 5'h10;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  // Reference model: an in-order queue of at most two entries. Pop on transfer
  // out, push on transfer in (accepted only when fewer than two are held).
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (mq.size() > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
        if (flush) begin
          mq.delete();
        end else begin
          bit acc;
          acc = in_valid && (mq.size() < 2);
          if (mq.size() > 0 && out_ready) void'(mq.pop_front());
          if (acc) mq.push_back(cur);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", {63'b0, in_ready}, {63'b0, (mq.size() < 2)});
        chk("out_valid", {63'b0, out_valid}, {63'b0, (mq.size() > 0)});
        chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
        if (mq.size() > 0) begin
          chk("out_pc", out_pc, mq[0].pc);
          chk("out_rs1_data", out_rs1_data, mq[0].rs1_data);
          chk("out_rs2_data", out_rs2_data, mq[0].rs2_data);
          chk("out_imm", out_imm, mq[0].imm);
          chk("out_funct3", 64'(out_funct3), 64'(mq[0].funct3));
          chk("out_rs1_addr", 64'(out_rs1_addr), 64'(mq[0].rs1_addr));
          chk("out_rs2_addr", 64'(out_rs2_addr), 64'(mq[0].rs2_addr));
          chk("out_rd_addr", 64'(out_rd_addr), 64'(mq[0].rd_addr));
          chk("out_ex_ctrl", 64'(out_ex_ctrl), 64'(mq[0].ex_ctrl));
          chk("out_m_ctrl", 64'(out_m_ctrl), 64'(mq[0].m_ctrl));
          chk("out_wb_ctrl", 64'(out_wb_ctrl), 64'(mq[0].wb_ctrl));
        end else begin
          chk("bubble_ctrl", 64'({out_ex_ctrl, out_m_ctrl, out_wb_ctrl}), 64'd0);
        end
        if (out_valid && (out_pc == 64'h200 || out_pc == 64'h20C)) seen_squashed = 1;
      end
    end
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    cur = mk(64'h0, 5'd0, 5'd0);
    #2;
    // Reset state.
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    do_reset();

    // Single instruction, one-cycle latency, then a bubble.
    cur = mk(64'h1000, 5'd5, 5'h1F); in_valid = 1; out_ready = 1;
    step();
    chk("single_valid", {63'b0, out_valid}, 64'd1);
    chk("single_pc", out_pc, 64'h1000);
    chk("single_rd", 64'(out_rd_addr), 64'd5);
    chk("single_ex", 64'(out_ex_ctrl), 64'h1F);
    in_valid = 0;
    step();
    chk("bubble_valid", {63'b0, out_valid}, 64'd0);
    chk("bubble_ctrl_lit", 64'({out_ex_ctrl, out_m_ctrl, out_wb_ctrl}), 64'd0);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      cur = mk(64'(4 * i), 5'(i + 1), 5'(i)); in_valid = 1;
      step();
      chk("stream_ready", {63'b0, in_ready}, 64'd1);
      chk("stream_pc", out_pc, 64'(4 * i));
    end
    in_valid = 0;
    step();
    chk("stream_drained", {63'b0, out_valid}, 64'd0);
    chk("stream_no_stall", 64'(stall_cnt), 64'd0);

    // Backpressure: fill both entries, stall four cycles, then drain in order.
    cur = mk(64'h100, 5'd1, 5'h02); in_valid = 1; out_ready = 1;
    step();
    cur = mk(64'h104, 5'd2, 5'h03); out_ready = 0;
    step();
    cur = mk(64'h108, 5'd3, 5'h04);
    step(); step(); step();
    chk("bp_full_ready", {63'b0, in_ready}, 64'd0);
    chk("bp_head", out_pc, 64'h100);
    chk("bp_stall4", 64'(stall_cnt), 64'd4);
    out_ready = 1;
    step();
    chk("bp_out1", out_pc, 64'h104);
    step();
    in_valid = 0;
    chk("bp_out2", out_pc, 64'h108);
    step();
    chk("bp_empty", {63'b0, out_valid}, 64'd0);
    chk("bp_stall_kept", 64'(stall_cnt), 64'd4);

    // Flush while FULL with a pending input.
    out_ready = 0;
    cur = mk(64'h300, 5'd7, 5'h05); in_valid = 1;
    step();
    cur = mk(64'h304, 5'd8, 5'h06);
    step();
    chk("fl_full", {63'b0, in_ready}, 64'd0);
    cur = mk(64'h200, 5'd9, 5'h07); flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("fl_valid", {63'b0, out_valid}, 64'd0);
    chk("fl_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1;
    step();
    // Flush while BUSY on an edge where the input would have transferred.
    cur = mk(64'h208, 5'd10, 5'h08); in_valid = 1;
    step();
    cur = mk(64'h20C, 5'd11, 5'h09); flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("fl_busy_valid", {63'b0, out_valid}, 64'd0);
    step();
    chk("fl_no_squashed", {63'b0, seen_squashed}, 64'd0);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    out_ready = 0;
    cur = mk(64'h400, 5'd12, 5'h0A); in_valid = 1;
    step();
    cur = mk(64'h404, 5'd13, 5'h0B);
    step();
    in_valid = 0;
    step(); step();
    chk("ar_pre_cnt", 64'(stall_cnt), 64'd3);
    chk("ar_pre_full", {63'b0, in_ready}, 64'd0);
    #2 rst = 1;
    #1;
    chk("ar_valid", {63'b0, out_valid}, 64'd0);
    chk("ar_ready", {63'b0, in_ready}, 64'd1);
    chk("ar_cnt", 64'(stall_cnt), 64'd0);
    chk("ar_pc", out_pc, 64'd0);
    chk("ar_data", out_rs1_data | out_rs2_data | out_imm, 64'd0);
    chk("ar_ctrl", 64'({out_ex_ctrl, out_m_ctrl, out_wb_ctrl, out_rd_addr}), 64'd0);
    step();
    rst = 0;

    // Counter saturation.
    cur = mk(64'h500, 5'd14, 5'h0C); in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    repeat (20) step();
    chk("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));
    out_ready = 1;
    step();
    chk("sat_drained", {63'b0, out_valid}, 64'd0);
    chk("sat_hold", 64'(stall_cnt), 64'(CNT_MAX));
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
Elastic ID/EX pipeline register for the five-stage core. Replaces the plain always-load register with a valid/ready handshake, a one-entry skid buffer, a synchronous flush for branch/exception squash, and a stall-cycle counter. Sits between the decode stage (upstream producer) and the execute stage (downstream consumer). It carries rs1/rs2 addresses so EX-side forwarding and hazard logic can use them.

Parameters:
PC_WIDTH, 64, program-counter width
REG_WIDTH, 64, register-file data width
REG_ADDR_W, 5, architectural register address width (32 GPRs, independent of REG_WIDTH)
EX_CTRL_W, 5, EX control-bundle width
M_CTRL_W, 5, MEM control-bundle width
WB_CTRL_W, 5, WB control-bundle width
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  squash all held and incoming instructions
in_valid  in  1  decode presents an instruction
in_ready  out  1  register can accept this cycle
in_pc  in  PC_WIDTH  instruction PC
in_rs1_data, in_rs2_data, in_imm  in  REG_WIDTH each  operands and immediate
in_funct3  in  3  funct3
in_rs1_addr, in_rs2_addr, in_rd_addr  in  REG_ADDR_W each  register addresses
in_ex_ctrl / in_m_ctrl / in_wb_ctrl  in  EX_CTRL_W / M_CTRL_W / WB_CTRL_W  control bundles
out_valid  out  1  EX-stage instruction valid
out_ready  in  1  EX consumes this cycle
out_* (pc, rs1_data, rs2_data, imm, funct3, rs1_addr, rs2_addr, rd_addr, ex_ctrl, m_ctrl, wb_ctrl)  out  widths as in_*  held instruction
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
- States: EMPTY (no entry), BUSY (main entry valid), FULL (main and skid entries valid). in_ready = (state != FULL), registered. out_valid = (state != EMPTY).
- EMPTY: in_valid -> load main, go BUSY. Latency 1 cycle.
- BUSY: in_valid & out_ready -> main <= input, stay BUSY (1 instr/cycle throughput). in_valid & !out_ready -> skid <= input, go FULL. !in_valid & out_ready -> go EMPTY. Otherwise hold.
- FULL: out_ready -> main <= skid, go BUSY. Otherwise hold. No input is accepted.
- Order is preserved; no instruction is duplicated or dropped except by flush.
- flush (synchronous, highest priority): next state EMPTY, in_ready=1 next cycle. Any instruction transferring in on the same edge is discarded. Payload registers need not be cleared.
- Bubble safety: out_ex_ctrl, out_m_ctrl and out_wb_ctrl are forced to 0 whenever out_valid=0. Other out_* fields are don't-care when invalid.
- stall_cnt: +1 per cycle with out_valid & !out_ready. Saturates at all-ones. Unaffected by flush.
- Reset (async, any state, mid-transfer included): state EMPTY, in_ready=1, out_valid=0, all out_* = 0, stall_cnt=0.

Decomposition:
- Package id_ex_pkg holds: the state enum (EMPTY/BUSY/FULL), default widths, and a packed payload struct/width constant (sum of all field widths).
- One natural sub-module: pipe_skid_buf. It is a generic WIDTH-parameterised 2-entry skid buffer with valid/ready and flush. The top level packs and unpacks the payload, applies control masking, and holds the counter.

Test Plan:
- Reset then single instruction: in_valid=1, pc=0x1000, rd=5, ex_ctrl=5'h1F, out_ready=1 -> next cycle out_valid=1, out_pc=0x1000, out_rd_addr=5. Following cycle (in_valid=0) out_valid=0 and ctrl outputs read 0.
- Streaming: 8 back-to-back instructions (pc 0x0,0x4,…,0x1C), out_ready=1 -> in_ready stays 1 and outputs appear in order, one per cycle, 1-cycle latency.
- Backpressure: stream pc 0x100,0x104,0x108 with out_ready=0 from cycle 2 -> state FULL, in_ready=0. Release after 4 cycles -> outputs 0x100,0x104,0x108 in order, none lost. stall_cnt=4.
- Flush in FULL with in_valid=1 (pc 0x200) -> next cycle out_valid=0, in_ready=1, 0x200 never appears at the output.
- Async reset asserted mid-stall (FULL, stall_cnt=3) -> immediately out_valid=0, stall_cnt=0, all outputs 0, in_ready=1.
- Saturation with CNT_W=4 and out_ready held 0 for 20 cycles -> stall_cnt stops at 15.
